// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, immediate formats, ALU ops, result mux selects.
// Imported by the decoder and the decode-stage pipeline registers.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_write;
    logic      jump;
    logic      branch;
    logic      alu_src;
    logic      illegal;
    res_src_e  result_src;
    alu_ctrl_e alu_ctrl;
    imm_src_e  imm_src;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational main decoder plus ALU decoder for one RV32I instruction.
// Zero latency; no flow control (pure function of the IF/ID fields).
module ctrl_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_valid,
  output ctrl_t      o_ctrl
);

  // Bit 30 means sub only for R-type; for OP-IMM it is part of the immediate except on shifts.
  function automatic alu_ctrl_e alu_dec(input logic [2:0] f3, input logic b30, input logic is_r);
    alu_ctrl_e op;
    case (f3)
      3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    o_ctrl            = '0;
    o_ctrl.result_src = RES_ALU;
    o_ctrl.alu_ctrl   = ALU_ADD;
    o_ctrl.imm_src    = IMM_I;
    case (i_opcode)
      OP_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_ctrl  = alu_dec(i_funct3, i_funct7b5, 1'b1);
      end
      OP_IMM: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_ctrl  = alu_dec(i_funct3, i_funct7b5, 1'b0);
      end
      OP_BRANCH: begin
        o_ctrl.branch   = 1'b1;
        o_ctrl.alu_ctrl = ALU_SUB;
        o_ctrl.imm_src  = IMM_B;
      end
      OP_JAL: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.imm_src    = IMM_J;
      end
      OP_JALR: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_ctrl  = ALU_PASSB;
        o_ctrl.imm_src   = IMM_U;
      end
      OP_AUIPC: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_U;
      end
      default: begin
        o_ctrl.illegal = i_valid;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID and ID/EX pipeline registers around the control decoder; one cycle per register.
// StallD holds IF/ID, FlushD/FlushE inject NOP/bubble; rst has top priority on both.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  input  logic        ValidF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  output logic [24:0] ImmD,
  output logic [2:0]  ImmSrcD,
  input  logic [31:0] ImmExtD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic        ValidE,
  output logic        IllegalE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  Funct3E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [31:0] ImmExtE
);

  logic [31:0] r_InstrD;
  logic [31:0] r_PCD;
  logic [31:0] r_PCPlus4D;
  logic        r_ValidD;
  ctrl_t       w_ctrl;

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      r_InstrD   <= NOP_INSTR;
      r_PCD      <= '0;
      r_PCPlus4D <= '0;
      r_ValidD   <= 1'b0;
    end else if (!StallD) begin
      r_InstrD   <= InstrF;
      r_PCD      <= PCF;
      r_PCPlus4D <= PCPlus4F;
      r_ValidD   <= ValidF;
    end
  end

  ctrl_decoder u_ctrl_decoder (
    .i_opcode   (r_InstrD[6:0]),
    .i_funct3   (r_InstrD[14:12]),
    .i_funct7b5 (r_InstrD[30]),
    .i_valid    (r_ValidD),
    .o_ctrl     (w_ctrl)
  );

  assign ImmD    = r_InstrD[31:7];
  assign ImmSrcD = w_ctrl.imm_src;
  assign Rs1D    = r_InstrD[19:15];
  assign Rs2D    = r_InstrD[24:20];

  // An invalid decode slot still carries its datapath fields; only side-effecting controls are gated.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ValidE      <= 1'b0;
      IllegalE    <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      Funct3E     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
    end else begin
      RegWriteE   <= w_ctrl.reg_write & r_ValidD;
      MemWriteE   <= w_ctrl.mem_write & r_ValidD;
      JumpE       <= w_ctrl.jump & r_ValidD;
      BranchE     <= w_ctrl.branch & r_ValidD;
      IllegalE    <= w_ctrl.illegal & r_ValidD;
      ValidE      <= r_ValidD;
      ALUSrcE     <= w_ctrl.alu_src;
      ResultSrcE  <= w_ctrl.result_src;
      ALUControlE <= w_ctrl.alu_ctrl;
      Funct3E     <= r_InstrD[14:12];
      Rs1E        <= r_InstrD[19:15];
      Rs2E        <= r_InstrD[24:20];
      RdE         <= r_InstrD[11:7];
      PCE         <= r_PCD;
      PCPlus4E    <= r_PCPlus4D;
      ImmExtE     <= ImmExtD;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrF, PCF, PCPlus4F, ImmExtD;
  logic        ValidF, StallD, FlushD, FlushE;
  logic [24:0] ImmD;
  logic [2:0]  ImmSrcD, Funct3E;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] PCE, PCPlus4E, ImmExtE;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .ImmD(ImmD), .ImmSrcD(ImmSrcD),
    .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ValidE(ValidE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE)
  );

  typedef struct {
    logic regw, memw, jump, branch, alusrc, illegal;
    logic [1:0] ressrc;
    logic [3:0] aluctl;
    logic [2:0] immsrc;
  } dec_t;

  typedef struct {
    logic regw, memw, jump, branch, alusrc, illegal, valid, zero;
    logic [1:0] ressrc;
    logic [3:0] aluctl;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] pc, pc4, imm;
  } ex_t;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  logic [31:0] mI, mPC, mPC4;
  logic        mV;
  ex_t         mE;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [31:0] imm_drv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU op by instruction meaning: add/sub, sll, slt, sltu, xor, srl/sra, or, and.
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b30, input logic is_r);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_r && b30) return 4'd1;
    if (f3 == 3'd5 && b30) return 4'd9;
    return tbl[f3];
  endfunction

  function automatic dec_t model_dec(input logic [31:0] ins, input logic v);
    dec_t d;
    d = '{default: '0};
    case (ins[6:0])
      7'b0000011: begin d.regw = 1; d.alusrc = 1; d.ressrc = 2'b01; end
      7'b0100011: begin d.memw = 1; d.alusrc = 1; d.immsrc = 3'd1; end
      7'b0110011: begin d.regw = 1; d.aluctl = ref_alu(ins[14:12], ins[30], 1'b1); end
      7'b0010011: begin d.regw = 1; d.alusrc = 1; d.aluctl = ref_alu(ins[14:12], ins[30], 1'b0); end
      7'b1100011: begin d.branch = 1; d.aluctl = 4'd1; d.immsrc = 3'd2; end
      7'b1101111: begin d.regw = 1; d.jump = 1; d.ressrc = 2'b10; d.immsrc = 3'd3; end
      7'b1100111: begin d.regw = 1; d.jump = 1; d.alusrc = 1; d.ressrc = 2'b10; end
      7'b0110111: begin d.regw = 1; d.alusrc = 1; d.aluctl = 4'd10; d.immsrc = 3'd4; end
      7'b0010111: begin d.regw = 1; d.alusrc = 1; d.immsrc = 3'd4; end
      default:    d.illegal = v;
    endcase
    return d;
  endfunction

  task automatic step(input logic [31:0] ins, input logic vf, input logic stall,
                      input logic fd, input logic fe, input logic r);
    dec_t d;
    InstrF = ins; ValidF = vf; StallD = stall; FlushD = fd; FlushE = fe; rst = r;
    PCF = pc_ctr; PCPlus4F = pc_ctr + 32'd4;
    imm_drv = 32'hA500_0000 ^ pc_ctr;
    ImmExtD = imm_drv;
    pc_ctr = pc_ctr + 32'd4;
    @(posedge clk);
    d = model_dec(mI, mV);
    if (r || fe) begin
      mE = '{default: '0};
      mE.zero = 1;
    end else begin
      mE.valid = mV; mE.zero = 0;
      mE.regw = d.regw & mV; mE.memw = d.memw & mV; mE.jump = d.jump & mV;
      mE.branch = d.branch & mV; mE.illegal = d.illegal & mV;
      mE.alusrc = d.alusrc; mE.ressrc = d.ressrc; mE.aluctl = d.aluctl;
      mE.f3 = mI[14:12]; mE.rs1 = mI[19:15]; mE.rs2 = mI[24:20]; mE.rd = mI[11:7];
      mE.pc = mPC; mE.pc4 = mPC4; mE.imm = ImmExtD;
    end
    if (r || fd) begin
      mI = 32'h0000_0013; mPC = 0; mPC4 = 0; mV = 0;
    end else if (!stall) begin
      mI = ins; mPC = PCF; mPC4 = PCPlus4F; mV = vf;
    end
    chk_en = 1;
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ImmD", {7'd0, ImmD}, {7'd0, mI[31:7]});
      chk("ImmSrcD", {29'd0, ImmSrcD}, {29'd0, model_dec(mI, mV).immsrc});
      chk("Rs1D", {27'd0, Rs1D}, {27'd0, mI[19:15]});
      chk("Rs2D", {27'd0, Rs2D}, {27'd0, mI[24:20]});
      chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, mE.regw});
      chk("MemWriteE", {31'd0, MemWriteE}, {31'd0, mE.memw});
      chk("JumpE", {31'd0, JumpE}, {31'd0, mE.jump});
      chk("BranchE", {31'd0, BranchE}, {31'd0, mE.branch});
      chk("IllegalE", {31'd0, IllegalE}, {31'd0, mE.illegal});
      chk("ValidE", {31'd0, ValidE}, {31'd0, mE.valid});
      if (mE.valid || mE.zero) begin
        chk("ALUSrcE", {31'd0, ALUSrcE}, {31'd0, mE.alusrc});
        chk("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, mE.ressrc});
        chk("ALUControlE", {28'd0, ALUControlE}, {28'd0, mE.aluctl});
        chk("Funct3E", {29'd0, Funct3E}, {29'd0, mE.f3});
        chk("Rs1E", {27'd0, Rs1E}, {27'd0, mE.rs1});
        chk("Rs2E", {27'd0, Rs2E}, {27'd0, mE.rs2});
        chk("RdE", {27'd0, RdE}, {27'd0, mE.rd});
        chk("PCE", PCE, mE.pc);
        chk("PCPlus4E", PCPlus4E, mE.pc4);
        chk("ImmExtE", ImmExtE, mE.imm);
      end
    end
  end

  localparam logic [31:0] NOPW = 32'h0000_0013;
  localparam logic [31:0] JALW = 32'h0080_00EF;
  logic [31:0] stream [16] = '{
    32'h0020_8463, 32'h0041_2083, 32'h0000_80E7, 32'h0000_1097,
    32'h0020_F1B3, 32'h4020_D1B3, 32'h0020_D1B3, 32'h0020_9093,
    32'h0030_B093, 32'h0020_A1B3, 32'h0040_C093, 32'h0020_E1B3,
    32'h0020_91B3, 32'h0020_B1B3, 32'h4000_8093, 32'h0020_D093
  };
  logic [31:0] sw_imm;

  initial begin
    rst = 1; InstrF = 0; PCF = 0; PCPlus4F = 0; ValidF = 0;
    StallD = 0; FlushD = 0; FlushE = 0; ImmExtD = 0;
    mI = NOPW; mPC = 0; mPC4 = 0; mV = 0; mE = '{default: '0};

    step(32'hFFFF_FFFF, 1, 0, 0, 0, 1);
    step(32'hFFFF_FFFF, 1, 0, 0, 0, 1);
    chk("rst_ValidE", {31'd0, ValidE}, 32'd0);
    chk("rst_IllegalE", {31'd0, IllegalE}, 32'd0);
    chk("rst_PCE", PCE, 32'd0);
    chk("rst_ImmD", {7'd0, ImmD}, 32'd0);

    step(32'h0050_0093, 1, 0, 0, 0, 0);
    chk("addi_ImmSrcD", {29'd0, ImmSrcD}, 32'd0);
    chk("addi_Rs1D", {27'd0, Rs1D}, 32'd0);
    step(32'h0011_2223, 1, 0, 0, 0, 0);
    chk("addi_RegWriteE", {31'd0, RegWriteE}, 32'd1);
    chk("addi_ALUSrcE", {31'd0, ALUSrcE}, 32'd1);
    chk("addi_ALUControlE", {28'd0, ALUControlE}, 32'd0);
    chk("addi_RdE", {27'd0, RdE}, 32'd1);
    chk("addi_ValidE", {31'd0, ValidE}, 32'd1);
    chk("sw_ImmSrcD", {29'd0, ImmSrcD}, 32'd1);
    chk("sw_ImmD", {7'd0, ImmD}, 32'h0000_2244);
    step(32'h4020_8033, 1, 0, 0, 0, 0);
    sw_imm = imm_drv;
    chk("sw_MemWriteE", {31'd0, MemWriteE}, 32'd1);
    chk("sw_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("sw_ImmExtE", ImmExtE, sw_imm);
    step(32'h4020_D093, 1, 0, 0, 0, 0);
    chk("sub_ALUControlE", {28'd0, ALUControlE}, 32'd1);
    step(32'h1234_5037, 1, 0, 0, 0, 0);
    chk("srai_ALUControlE", {28'd0, ALUControlE}, 32'd9);
    step(JALW, 1, 0, 0, 0, 0);
    chk("lui_ALUControlE", {28'd0, ALUControlE}, 32'd10);
    step(stream[0], 1, 0, 0, 0, 0);
    chk("jal_JumpE", {31'd0, JumpE}, 32'd1);
    chk("jal_ResultSrcE", {30'd0, ResultSrcE}, 32'd2);
    for (int i = 1; i < 16; i++) step(stream[i], 1, 0, 0, 0, 0);

    step(32'h0030_0113, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(32'h0040_0193, 1, 1, 0, 1, 0);
      chk("stall_Rs2D", {27'd0, Rs2D}, 32'd3);
      chk("stall_ValidE", {31'd0, ValidE}, 32'd0);
    end
    step(32'h0040_0193, 1, 0, 0, 0, 0);
    chk("resume_RdE", {27'd0, RdE}, 32'd2);
    chk("resume_ValidE", {31'd0, ValidE}, 32'd1);
    step(NOPW, 1, 0, 0, 0, 0);
    chk("resume_next_RdE", {27'd0, RdE}, 32'd3);

    step(32'h0050_0093, 1, 0, 0, 0, 0);
    step(JALW, 1, 1, 1, 0, 0);
    chk("flushD_ImmD", {7'd0, ImmD}, 32'd0);
    chk("flushD_Rs2D", {27'd0, Rs2D}, 32'd0);
    step(NOPW, 1, 0, 0, 0, 0);
    chk("flushD_JumpE", {31'd0, JumpE}, 32'd0);
    chk("flushD_ValidE", {31'd0, ValidE}, 32'd0);

    step(32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    step(NOPW, 1, 0, 0, 0, 0);
    chk("ill_IllegalE", {31'd0, IllegalE}, 32'd1);
    chk("ill_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("ill_MemWriteE", {31'd0, MemWriteE}, 32'd0);
    step(32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    step(NOPW, 1, 0, 0, 0, 0);
    chk("inv_IllegalE", {31'd0, IllegalE}, 32'd0);

    step(32'h0050_0093, 1, 0, 0, 0, 0);
    step(32'h0011_2223, 1, 1, 0, 0, 0);
    step(32'h0011_2223, 1, 1, 0, 0, 1);
    chk("rststall_ImmSrcD", {29'd0, ImmSrcD}, 32'd0);
    chk("rststall_ValidE", {31'd0, ValidE}, 32'd0);
    step(NOPW, 1, 0, 0, 0, 0);
    chk("rststall_next_ValidE", {31'd0, ValidE}, 32'd0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
